fifo_byte_serializer: RTL and testbench
=======================================

Name: fifo_byte_serializer

Overview:
- Drain stage directly downstream of the 16-bit synchronous FIFO (8-deep, write-priority, registered data_out).
- Pops one word at a time, splits it into two bytes MSB-first, and presents them on a valid/ready byte stream toward the link/UART-side packer.
- Groups words into fixed-length bursts and marks the last byte of each burst.

Parameters:
- BURST_LEN, 4, words per burst. Legal range 1..255. Drives m_last and the checksum boundary.
- CNT_W, 8, width of the burst word counter. Must satisfy 2**CNT_W > BURST_LEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_write  in  1  snoop of the FIFO write strobe; the FIFO ignores a read in any cycle where write is accepted
- fifo_rd  out  1  FIFO read strobe
- fifo_dout  in  16  FIFO data_out; valid exactly one cycle after an accepted read, zero otherwise
- m_data  out  8  output byte
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accept
- m_last  out  1  last byte of burst, qualified by m_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE, fifo_rd 0, m_valid 0, m_data 0x00, m_last 0, busy 0, word_cnt 0, word_reg 0, csum 0.
- Reset asserted mid-operation discards the held word and any partial checksum. It does not re-pop. Outputs reach reset values on the next edge.
- State IDLE:
  - fifo_rd = !fifo_empty && !fifo_write (combinational, IDLE only).
  - When fifo_rd = 1, go to CAPTURE.
  - fifo_rd is never asserted when fifo_write = 1, so every issued read is guaranteed accepted.
- State CAPTURE:
  - word_reg <= fifo_dout.
  - m_data <= fifo_dout[15:8], m_valid <= 1.
  - Go to SEND_HI.
- State SEND_HI:
  - Hold m_data and m_valid while m_ready = 0.
  - On m_valid && m_ready: m_data <= word_reg[7:0], go to SEND_LO.
  - m_last is set for the low byte when word_cnt == BURST_LEN-1 and the checksum is disabled.
- State SEND_LO: on handshake:
  - If word_cnt != BURST_LEN-1: word_cnt++, m_valid <= 0, m_last <= 0, go to IDLE.
  - Else: word_cnt <= 0, then go to IDLE (checksum disabled) or SEND_CS (checksum enabled).
- Handshake rules:
  - A byte transfers on the rising edge where m_valid && m_ready.
  - m_data, m_valid and m_last are stable while m_valid && !m_ready.
  - m_valid never drops without a transfer, except on rst.
- Throughput: at most 2 bytes per 4 cycles (IDLE, CAPTURE, SEND_HI, SEND_LO). No pop overlaps a send.
- Ordering: bytes emerge in FIFO order, high byte then low byte. No word is dropped or duplicated.
- Empty FIFO: the block sits in IDLE with fifo_rd = 0 and m_valid = 0. A partial burst waits indefinitely; word_cnt is kept.
- Full FIFO: no special handling. Draining resumes normally.
- word_cnt wraps to 0 only at the burst boundary or on rst.

Optional Feature:
- Macro: SER_CHECKSUM_EN.
- Defined:
  - csum (8-bit) XOR-accumulates every transferred data byte of the burst.
  - After the final low-byte handshake, state SEND_CS presents m_data = csum with m_valid = 1 and m_last = 1.
  - The low byte carries m_last = 0.
  - On handshake, csum <= 0, m_valid <= 0, go to IDLE.
- Undefined:
  - No csum register and no SEND_CS state.
  - m_last is asserted on the final low byte of each burst.

Test Plan:
- Release rst with fifo_empty = 1 for 20 cycles -> fifo_rd, m_valid and busy stay 0; m_data = 0x00.
- FIFO holds 0xA55A, m_ready = 1 -> fifo_rd pulses 1 cycle; bytes 0xA5 then 0x5A transfer on the 2nd and 3rd cycles after the pop; m_last = 0 (BURST_LEN = 4).
- Same word, m_ready low 3 cycles in SEND_HI -> m_data holds 0xA5 with m_valid = 1 for all 3 cycles, then 0x5A follows after m_ready rises.
- fifo_empty = 0 with fifo_write = 1 for 5 cycles in IDLE -> fifo_rd stays 0 throughout; pops on the first cycle fifo_write = 0; the word read is the oldest entry.
- Burst 0x0102, 0x0304, 0x0506, 0x0708, BURST_LEN = 4:
  - Without macro: output 01 02 03 04 05 06 07 08, m_last only on 0x08.
  - With SER_CHECKSUM_EN: extra byte 0x08 (XOR of bytes 01..08) with m_last; the data byte 0x08 has m_last = 0.
- rst pulsed during SEND_LO of word 2 of a burst -> next cycle m_valid = 0 and busy = 0. Subsequent words restart a fresh burst: m_last after 4 new words; checksum covers only post-reset bytes.

Source files
------------

// File: rtl/fifo_byte_serializer.sv
// -----------------------------------------------------------------------------
// fifo_byte_serializer
//
// Drain stage for the 16-bit synchronous FIFO. Pops one word at a time,
// emits it as two bytes (high byte first) on a valid/ready byte stream and
// groups words into bursts of BURST_LEN words, flagging the last byte of
// each burst with m_last.
//
// Optional feature (compile-time macro SER_CHECKSUM_EN):
//   When defined, an XOR checksum of all data bytes of the burst is appended
//   as an extra byte after the final low byte. That checksum byte carries
//   m_last and the final low byte does not.
//   When undefined, there is no checksum logic and m_last marks the final
//   low byte of each burst.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous, active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_write  in   snoop of the FIFO write strobe (write beats read)
//   fifo_rd     out  FIFO read strobe, combinational, asserted only in IDLE
//   fifo_dout   in   FIFO read data, valid the cycle after an accepted read
//   m_data      out  output byte
//   m_valid     out  output byte valid
//   m_ready     in   downstream accept
//   m_last      out  last byte of burst, qualified by m_valid
//   busy        out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module fifo_byte_serializer #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic        fifo_write,
    output logic        fifo_rd,
    input  logic [15:0] fifo_dout,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
`ifdef SER_CHECKSUM_EN
    localparam int unsigned STATE_W = 3;
`else
    localparam int unsigned STATE_W = 2;
`endif

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SEND_HI,
        ST_SEND_LO
`ifdef SER_CHECKSUM_EN
        ,
        ST_SEND_CS
`endif
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WORD_W-1:0]   word_reg_q;
    logic [WORD_W-1:0]   word_reg_d;
    logic [BYTE_W-1:0]   m_data_q;
    logic [BYTE_W-1:0]   m_data_d;
    logic                m_valid_q;
    logic                m_valid_d;
    logic                m_last_q;
    logic                m_last_d;
    logic                busy_q;
    logic                busy_d;
    logic [CNT_W-1:0]    word_cnt_q;
    logic [CNT_W-1:0]    word_cnt_d;
`ifdef SER_CHECKSUM_EN
    logic [BYTE_W-1:0]   csum_q;
    logic [BYTE_W-1:0]   csum_d;
`endif

    logic                xfer;
    logic                last_word;
    logic                pop;

    // A byte moves on every edge where the presented byte is accepted.
    assign xfer      = m_valid_q & m_ready;
    assign last_word = (word_cnt_q == LAST_WORD);

    // Never read while the FIFO is accepting a write, so every issued read
    // is accepted; suppressed during reset so a reset never starts a pop.
    assign pop     = (state_q == ST_IDLE) & ~fifo_empty & ~fifo_write & ~rst;
    assign fifo_rd = pop;

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (xfer) begin
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (xfer) begin
`ifdef SER_CHECKSUM_EN
                    state_d = last_word ? ST_SEND_CS : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef SER_CHECKSUM_EN
            ST_SEND_CS: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        word_reg_d = word_reg_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        word_cnt_d = word_cnt_q;
`ifdef SER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        busy_d     = (state_d != ST_IDLE);

        unique case (state_q)
            ST_CAPTURE: begin
                // fifo_dout is valid in this cycle only.
                word_reg_d = fifo_dout;
                m_data_d   = fifo_dout[15:8];
                m_valid_d  = 1'b1;
                m_last_d   = 1'b0;
            end
            ST_SEND_HI: begin
                if (xfer) begin
                    m_data_d = word_reg_q[7:0];
`ifdef SER_CHECKSUM_EN
                    csum_d   = csum_q ^ m_data_q;
                    m_last_d = 1'b0;
`else
                    m_last_d = last_word;
`endif
                end else begin
                    // Holds the presented high byte while stalled.
                    m_data_d = word_reg_q[15:8];
                end
            end
            ST_SEND_LO: begin
                if (xfer) begin
                    if (!last_word) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        m_valid_d  = 1'b0;
                        m_last_d   = 1'b0;
                    end else begin
                        word_cnt_d = '0;
`ifdef SER_CHECKSUM_EN
                        // Checksum byte follows directly; it folds in the
                        // low byte being accepted on this edge.
                        csum_d     = csum_q ^ m_data_q;
                        m_data_d   = csum_q ^ m_data_q;
                        m_last_d   = 1'b1;
`else
                        m_valid_d  = 1'b0;
                        m_last_d   = 1'b0;
`endif
                    end
`ifdef SER_CHECKSUM_EN
                    if (!last_word) begin
                        csum_d = csum_q ^ m_data_q;
                    end
`endif
                end
            end
`ifdef SER_CHECKSUM_EN
            ST_SEND_CS: begin
                if (xfer) begin
                    csum_d    = '0;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg_q <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            word_cnt_q <= '0;
`ifdef SER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            word_reg_q <= word_reg_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            busy_q     <= busy_d;
            word_cnt_q <= word_cnt_d;
`ifdef SER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// -----------------------------------------------------------------------------
// Bench for fifo_byte_serializer: a small FIFO model feeds the design, and a
// word-level scoreboard predicts the byte stream (high byte, low byte, burst
// boundaries, optional XOR checksum) from the words written into the FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_byte_serializer;

    localparam int unsigned TB_BURST = 4;
`ifdef SER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_write;
    logic        fifo_rd;
    logic [15:0] fifo_dout;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic [15:0] wdata;

    fifo_byte_serializer #(
        .BURST_LEN (TB_BURST),
        .CNT_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_write (fifo_write),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO model: write-priority, data_out registered, zero when idle.
    logic [15:0] mem [0:15];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    initial fifo_dout = 16'h0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        fifo_dout <= 16'h0;
        if (fifo_write) begin
            mem[wr_ptr % 16] <= wdata;
            wr_ptr <= wr_ptr + 1;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr % 16];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Scoreboard state.
    logic [15:0] exp_words[$];
    exp_t        pend[$];
    logic [7:0]  burst_bytes[$];
    logic [8:0]  obs_log[$];
    int          bidx = 0;
    logic        stall_prev = 1'b0;
    logic [9:0]  prev_vec = '0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Turn the next written word into its expected bytes.
    task automatic refill();
        logic [15:0] w;
        logic [7:0]  cs;
        bit          lastw;
        if (exp_words.size() == 0) return;
        w = exp_words.pop_front();
        lastw = (bidx == TB_BURST - 1);
        burst_bytes.push_back(w[15:8]);
        burst_bytes.push_back(w[7:0]);
        pend.push_back('{last: 1'b0, data: w[15:8]});
        pend.push_back('{last: 1'(lastw && !CS_EN), data: w[7:0]});
        if (lastw) begin
            if (CS_EN) begin
                cs = 8'h00;
                foreach (burst_bytes[i]) cs = cs ^ burst_bytes[i];
                pend.push_back('{last: 1'b1, data: cs});
            end
            burst_bytes.delete();
            bidx = 0;
        end else begin
            bidx = bidx + 1;
        end
    endtask

    task automatic model_reset();
        pend.delete();
        burst_bytes.delete();
        bidx = 0;
        stall_prev = 1'b0;
    endtask

    // Observes the stream between edges.
    task automatic monitor();
        exp_t e;
        chk("rd_during_write", 32'(fifo_rd & fifo_write), 32'h0);
        if (stall_prev) begin
            chk("hold_while_stalled", 32'({m_valid, m_last, m_data}), 32'(prev_vec));
        end
        if (m_valid && m_ready) begin
            if (pend.size() == 0) refill();
            if (pend.size() == 0) begin
                chk("unexpected_byte", 32'h1, 32'h0);
            end else begin
                e = pend.pop_front();
                chk("byte_data", 32'(m_data), 32'(e.data));
                chk("byte_last", 32'(m_last), 32'(e.last));
            end
            obs_log.push_back({m_last, m_data});
        end
        stall_prev = m_valid && !m_ready;
        prev_vec   = {m_valid, m_last, m_data};
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        fifo_write = 1'b1;
        wdata      = w;
        exp_words.push_back(w);
    endtask

    task automatic drain(input bit rand_ready, input int budget);
        bit done;
        done = 1'b0;
        fifo_write = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fifo_empty && !busy && !m_valid) begin
                done = 1'b1;
                break;
            end
            m_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            cyc();
        end
        chk("drain_done", 32'(done), 32'h1);
        chk("all_words_out", 32'(exp_words.size() + pend.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_seq[$];
        bit         found;
        int         nlast;

        rst        = 1'b1;
        fifo_write = 1'b0;
        wdata      = 16'h0;
        m_ready    = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;

        // Idle after reset with an empty FIFO.
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("idle_fifo_rd", 32'(fifo_rd), 32'h0);
            chk("idle_m_valid", 32'(m_valid), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_m_data", 32'(m_data), 32'h0);
            cyc();
        end

        // Single word, downstream always ready.
        m_ready = 1'b1;
        push(16'hA55A);
        #1 chk("rd_low_on_write", 32'(fifo_rd), 32'h0);
        cyc();
        fifo_write = 1'b0;
        #1 chk("pop_pulse", 32'(fifo_rd), 32'h1);
        chk("busy_before_pop", 32'(busy), 32'h0);
        cyc();
        #1 chk("capture_rd_low", 32'(fifo_rd), 32'h0);
        chk("capture_busy", 32'(busy), 32'h1);
        chk("capture_no_valid", 32'(m_valid), 32'h0);
        cyc();
        #1 chk("hi_valid", 32'(m_valid), 32'h1);
        chk("hi_data", 32'(m_data), 32'hA5);
        cyc();
        #1 chk("lo_data", 32'(m_data), 32'h5A);
        chk("lo_last", 32'(m_last), 32'h0);
        chk("lo_valid", 32'(m_valid), 32'h1);
        cyc();
        #1 chk("after_word_valid", 32'(m_valid), 32'h0);
        chk("after_word_busy", 32'(busy), 32'h0);

        // Same word with three stall cycles on the high byte.
        m_ready = 1'b0;
        push(16'hA55A);
        cyc();
        fifo_write = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_valid", 32'(m_valid), 32'h1);
            chk("stall_data", 32'(m_data), 32'hA5);
            cyc();
        end
        m_ready = 1'b1;
        #1 chk("stall_release_data", 32'(m_data), 32'hA5);
        cyc();
        #1 chk("stall_lo_data", 32'(m_data), 32'h5A);
        cyc();
        #1 chk("stall_done_valid", 32'(m_valid), 32'h0);

        // Writes block pops while the FIFO is non-empty.
        for (int i = 0; i < 6; i++) begin
            push(16'($urandom));
            #1;
            if (i > 0) chk("write_blocks_pop", 32'(fifo_rd), 32'h0);
            cyc();
        end
        fifo_write = 1'b0;
        #1 chk("pop_after_write", 32'(fifo_rd), 32'h1);
        drain(1'b0, 100);

        // Aligned burst of four known words.
        obs_log.delete();
        push(16'h0102); cyc();
        push(16'h0304); cyc();
        push(16'h0506); cyc();
        push(16'h0708); cyc();
        drain(1'b0, 100);
        for (int b = 1; b <= 8; b++) exp_seq.push_back({1'((b == 8) && !CS_EN), 8'(b)});
        if (CS_EN) exp_seq.push_back({1'b1, 8'h08});
        chk("burst_len", 32'(obs_log.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < obs_log.size(); i++) begin
            chk("burst_byte", 32'(obs_log[i]), 32'(exp_seq[i]));
        end

        // Reset while the low byte of the second word is presented.
        m_ready = 1'b1;
        push(16'h1112); cyc();
        push(16'h2122); cyc();
        fifo_write = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_valid && m_data == 8'h22) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk("reach_send_lo", 32'(found), 32'h1);
        m_ready = 1'b0;
        rst = 1'b1;
        cyc();
        model_reset();
        rst = 1'b0;
        #1 chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_m_last", 32'(m_last), 32'h0);
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_no_repop", 32'(fifo_rd), 32'h0);

        // Fresh burst after reset.
        obs_log.delete();
        for (int i = 0; i < 4; i++) begin
            push(16'($urandom));
            cyc();
        end
        drain(1'b1, 300);
        chk("post_rst_bytes", 32'(obs_log.size()), 32'(8 + int'(CS_EN)));
        nlast = 0;
        foreach (obs_log[i]) nlast += int'(obs_log[i][8]);
        chk("post_rst_last_count", 32'(nlast), 32'h1);
        if (obs_log.size() > 0) chk("post_rst_last_pos", 32'(obs_log[obs_log.size()-1][8]), 32'h1);

        // Random writes and backpressure.
        for (int i = 0; i < 120; i++) begin
            if ((wr_ptr - rd_ptr) < 6 && $urandom_range(2) == 0) begin
                push(16'($urandom));
            end else begin
                fifo_write = 1'b0;
            end
            m_ready = ($urandom_range(3) != 0);
            cyc();
        end
        drain(1'b1, 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
